regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port successor to the 8086 general-purpose register file. It holds the eight 16-bit GPRs (AX, CX, DX, BX, SP, BP, SI, DI) and provides NUM_RD registered read ports, NUM_WR write ports with byte-lane merging and same-cycle read bypass. A shadow bank supports single-cycle save, restore and swap of the full register set for fast interrupt context switching. It sits between the microcode sequencer/ALU writeback and the address generator, which consumes the direct SI/DI/BP/BX/SP outputs.

## Interface
- NUM_RD, 2: number of read ports (1..4).
- NUM_WR, 1: number of write ports (1..2); higher index has priority.
- DATA_W, 16: register width; must be 16 (byte-lane logic assumes 2 lanes).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_sel  in  [NUM_RD][3]  read register select.
- rd_is_8_bit  in  [NUM_RD]  1: select is a byte register; value returned zero-extended.
- rd_val  out  [NUM_RD][DATA_W]  registered read data.
- wr_sel  in  [NUM_WR][3]  write register select.
- wr_is_8_bit  in  [NUM_WR]  1: byte write using wr_val[7:0].
- wr_val  in  [NUM_WR][DATA_W]  write data.
- wr_en  in  [NUM_WR]  write enable.
- save  in  1  copy the post-write register state into the shadow bank.
- restore  in  1  load the shadow bank into the main bank.
- si, di, bp, bx, sp  out  16 each  direct combinational views of the main-bank registers.

## Operation
- 16-bit encoding: 0 AX, 1 CX, 2 DX, 3 BX, 4 SP, 5 BP, 6 SI, 7 DI.
- 8-bit encoding: sel[2]=0 selects the low byte of register sel[1:0] (AL/CL/DL/BL); sel[2]=1 selects its high byte (AH/CH/DH/BH).
- A byte write modifies only the addressed lane. The other lane holds its value.
- Multiple writes in one cycle merge per byte lane. When two ports hit the same lane, the higher port index wins. Writes to different lanes of one register (e.g. port0 AL, port1 AH) both land.
- next_state = restore ? shadow : (main with merged writes applied).
- save with restore clear: shadow <= main with merged writes applied.
- save and restore together: swap, i.e. main <= shadow and shadow <= old main. Writes in that cycle are discarded.
- restore alone: writes in that cycle are discarded; the shadow bank is unchanged.
- Read: rd_val[i] <= selected field of next_state. Reads therefore bypass same-cycle writes and restores.
- Byte reads return {8'h00, byte}.
- Reset clears both banks and all rd_val to 0. Direct outputs read 0 during reset.

## Timing
- Write latency: a write is visible on the direct outputs after the rising edge that samples wr_en.
- Read latency: 1 cycle. rd_sel sampled at edge N produces rd_val valid after edge N and held until edge N+1.
- Bypass: with rd_sel == wr_sel and wr_en in the same cycle, rd_val shows the new data after the same edge, with no stale cycle.
- save/restore are single-cycle pulses. A level held for k cycles repeats the action k times; back-to-back swaps alternate the banks.
- Reset assertion mid-operation zeroes all state immediately (asynchronous). The first write is accepted on the first edge with reset low.
- No handshake: every port is accepted every cycle, so there are no stalls.

## Structure
- Package regfile_pkg:
  - reg_idx_e enum: AX..DI.
  - byte-register localparams: AL..BH.
  - function lane_of(sel, is_8_bit) returning register index plus 2-bit lane mask.
  - function extract(reg, sel, is_8_bit).
- Sub-module regfile_read_port: one instance per read port. It is a mux over next_state plus the rd_val flop with async reset.
- Write merge, shadow bank and control stay in the top module.

## Test plan
- Reset, then 16-bit write CX=16'h5678 with rd_sel[0]=CX in the same cycle -> rd_val[0]=16'h5678 after that edge (bypass); reading AX gives 16'h0000.
- AX=16'h1200, then byte write AL=8'hAA, then AH=8'hBB -> AX=16'hBBAA. A byte read of AH on port 1 returns 16'h00BB.
- NUM_WR=2: port0 writes BX=16'h1111 and port1 writes BL=8'h22 in one cycle -> bx=16'h1122. Port0 AL=8'h33 with port1 AH=8'h44 -> AX=16'h4433.
- Write SI=16'hA5A5, pulse save, write SI=16'h0001, pulse restore -> si=16'hA5A5. A write to SI in the restore cycle is discarded.
- Main SI=16'h1, shadow SI=16'h2, save and restore together -> si=16'h2; repeat the swap -> si=16'h1.
- Assert reset asynchronously between edges after loading BP=16'h3C3C -> bp and all rd_val read 0 immediately. Writes are accepted again on the first edge after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port 8086 GPR file:
// register/byte encodings and the select-to-lane decode used by writes and reads.
package regfile_pkg;

    localparam int REG_N = 8;
    localparam int REG_W = 16;

    typedef logic [REG_W-1:0] word_t;

    typedef enum logic [2:0] {
        AX = 3'd0,
        CX = 3'd1,
        DX = 3'd2,
        BX = 3'd3,
        SP = 3'd4,
        BP = 3'd5,
        SI = 3'd6,
        DI = 3'd7
    } reg_idx_e;

    localparam logic [2:0] AL = 3'd0;
    localparam logic [2:0] CL = 3'd1;
    localparam logic [2:0] DL = 3'd2;
    localparam logic [2:0] BL = 3'd3;
    localparam logic [2:0] AH = 3'd4;
    localparam logic [2:0] CH = 3'd5;
    localparam logic [2:0] DH = 3'd6;
    localparam logic [2:0] BH = 3'd7;

    // lane[0] is bits 7:0, lane[1] is bits 15:8
    typedef struct packed {
        logic [2:0] idx;
        logic [1:0] lane;
    } lane_t;

    function automatic lane_t lane_of(input logic [2:0] sel, input logic is_8_bit);
        lane_t l;
        if (is_8_bit) begin
            l.idx  = {1'b0, sel[1:0]};
            l.lane = sel[2] ? 2'b10 : 2'b01;
        end else begin
            l.idx  = sel;
            l.lane = 2'b11;
        end
        return l;
    endfunction

    // value is the register already picked by lane_of(sel, is_8_bit).idx
    function automatic word_t extract(input word_t value, input logic [2:0] sel,
                                      input logic is_8_bit);
        if (!is_8_bit)
            return value;
        return sel[2] ? {8'h00, value[15:8]} : {8'h00, value[7:0]};
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: selects a register (or byte) from the
// post-update register state and holds it until the next edge.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [REG_N-1:0][DATA_W-1:0]  next_state,
    input  logic [2:0]                    rd_sel,
    input  logic                          rd_is_8_bit,
    output logic [DATA_W-1:0]             rd_val
);

    lane_t             rd_lane;
    logic [DATA_W-1:0] rd_d;

    always_comb begin
        rd_lane = lane_of(rd_sel, rd_is_8_bit);
        rd_d    = extract(next_state[rd_lane.idx], rd_sel, rd_is_8_bit);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_val <= '0;
        else
            rd_val <= rd_d;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port 8086 GPR file with byte-lane write merge, bypassed registered
// reads and a shadow bank for single-cycle save/restore/swap.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int DATA_W = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD-1:0][2:0]         rd_sel,
    input  logic [NUM_RD-1:0]              rd_is_8_bit,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_val,
    input  logic [NUM_WR-1:0][2:0]         wr_sel,
    input  logic [NUM_WR-1:0]              wr_is_8_bit,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_val,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic                           save,
    input  logic                           restore,
    output logic [DATA_W-1:0]              si,
    output logic [DATA_W-1:0]              di,
    output logic [DATA_W-1:0]              bp,
    output logic [DATA_W-1:0]              bx,
    output logic [DATA_W-1:0]              sp
);

    logic [REG_N-1:0][DATA_W-1:0] main_q;
    logic [REG_N-1:0][DATA_W-1:0] shadow_q;
    logic [REG_N-1:0][DATA_W-1:0] merged;
    logic [REG_N-1:0][DATA_W-1:0] next_state;
    lane_t                        wr_lane [NUM_WR];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        merged = main_q;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_lane[w] = lane_of(wr_sel[w], wr_is_8_bit[w]);
            // ascending port order: a later port overwrites the same lane, so the higher index wins
            if (wr_en[w]) begin
                if (wr_lane[w].lane[0])
                    merged[wr_lane[w].idx][7:0] = wr_val[w][7:0];
                if (wr_lane[w].lane[1])
                    merged[wr_lane[w].idx][15:8] = wr_is_8_bit[w] ? wr_val[w][7:0]
                                                                  : wr_val[w][15:8];
            end
        end
        next_state = restore ? shadow_q : merged;
    end

    // NOTE: both register banks are architecturally cleared on reset, so they are real flops, not RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q   <= '0;
            shadow_q <= '0;
        end else begin
            main_q <= next_state;
            // save+restore swaps with the old main bank; writes in that cycle are dropped
            if (save)
                shadow_q <= restore ? main_q : merged;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        regfile_read_port #(.DATA_W(DATA_W)) u_read_port (
            .clk         (clk),
            .reset       (reset),
            .next_state  (next_state),
            .rd_sel      (rd_sel[r]),
            .rd_is_8_bit (rd_is_8_bit[r]),
            .rd_val      (rd_val[r])
        );
    end

    assign si = main_q[SI];
    assign di = main_q[DI];
    assign bp = main_q[BP];
    assign bx = main_q[BX];
    assign sp = main_q[SP];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp with two read and two write ports.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int NRD = 2;
    localparam int NWR = 2;

    localparam int SRC_RD0 = 0;
    localparam int SRC_RD1 = 1;
    localparam int SRC_SI  = 2;
    localparam int SRC_DI  = 3;
    localparam int SRC_BP  = 4;
    localparam int SRC_BX  = 5;
    localparam int SRC_SP  = 6;

    logic                  clk;
    logic                  reset;
    logic [NRD-1:0][2:0]   rd_sel;
    logic [NRD-1:0]        rd_is_8_bit;
    logic [NRD-1:0][15:0]  rd_val;
    logic [NWR-1:0][2:0]   wr_sel;
    logic [NWR-1:0]        wr_is_8_bit;
    logic [NWR-1:0][15:0]  wr_val;
    logic [NWR-1:0]        wr_en;
    logic                  save;
    logic                  restore;
    logic [15:0]           si, di, bp, bx, sp;

    int checks;
    int errors;

    string       tag_q [$];
    int          src_q [$];
    logic [15:0] val_q [$];

    regfile_mp #(.NUM_RD(NRD), .NUM_WR(NWR), .DATA_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_sel      (rd_sel),
        .rd_is_8_bit (rd_is_8_bit),
        .rd_val      (rd_val),
        .wr_sel      (wr_sel),
        .wr_is_8_bit (wr_is_8_bit),
        .wr_val      (wr_val),
        .wr_en       (wr_en),
        .save        (save),
        .restore     (restore),
        .si          (si),
        .di          (di),
        .bp          (bp),
        .bx          (bx),
        .sp          (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] observe(input int src);
        case (src)
            SRC_RD0: return rd_val[0];
            SRC_RD1: return rd_val[1];
            SRC_SI:  return si;
            SRC_DI:  return di;
            SRC_BP:  return bp;
            SRC_BX:  return bx;
            SRC_SP:  return sp;
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic exp_push(input string tag, input int src, input logic [15:0] v);
        tag_q.push_back(tag);
        src_q.push_back(src);
        val_q.push_back(v);
    endtask

    task automatic compare_all();
        string       t;
        int          s;
        logic [15:0] e;
        logic [15:0] o;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            s = src_q.pop_front();
            e = val_q.pop_front();
            o = observe(s);
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, o, e);
            end
        end
    endtask

    task automatic idle();
        wr_en   = '0;
        save    = 1'b0;
        restore = 1'b0;
    endtask

    task automatic wr(input int p, input logic [2:0] sel, input logic is8, input logic [15:0] v);
        wr_en[p]       = 1'b1;
        wr_sel[p]      = sel;
        wr_is_8_bit[p] = is8;
        wr_val[p]      = v;
    endtask

    task automatic rd(input int p, input logic [2:0] sel, input logic is8);
        rd_sel[p]      = sel;
        rd_is_8_bit[p] = is8;
    endtask

    // one clock: sample #1 after the rising edge, then reopen inputs for the next cycle
    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
        idle();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        rd_sel      = '0;
        rd_is_8_bit = '0;
        wr_sel      = '0;
        wr_is_8_bit = '0;
        wr_val      = '0;
        idle();

        #12;
        exp_push("reset_rd0", SRC_RD0, 16'h0000);
        exp_push("reset_rd1", SRC_RD1, 16'h0000);
        exp_push("reset_si",  SRC_SI,  16'h0000);
        exp_push("reset_sp",  SRC_SP,  16'h0000);
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        wr(0, CX, 1'b0, 16'h5678);
        rd(0, CX, 1'b0);
        rd(1, AX, 1'b0);
        exp_push("bypass_cx", SRC_RD0, 16'h5678);
        exp_push("read_ax_zero", SRC_RD1, 16'h0000);
        tick();

        wr(0, AX, 1'b0, 16'h1200);
        rd(0, AX, 1'b0);
        exp_push("ax_full", SRC_RD0, 16'h1200);
        tick();

        wr(0, AL, 1'b1, 16'h77AA);
        exp_push("al_write", SRC_RD0, 16'h12AA);
        tick();

        wr(0, AH, 1'b1, 16'h00BB);
        rd(1, AH, 1'b1);
        exp_push("ah_write", SRC_RD0, 16'hBBAA);
        exp_push("ah_byte_read", SRC_RD1, 16'h00BB);
        tick();

        wr(0, BX, 1'b0, 16'h1111);
        wr(1, BL, 1'b1, 16'h0022);
        rd(0, BX, 1'b0);
        rd(1, BL, 1'b1);
        exp_push("merge_bx_rd", SRC_RD0, 16'h1122);
        exp_push("merge_bl_rd", SRC_RD1, 16'h0022);
        tick();
        exp_push("merge_bx_direct", SRC_BX, 16'h1122);
        compare_all();

        wr(0, AL, 1'b1, 16'h0033);
        wr(1, AH, 1'b1, 16'h0044);
        rd(0, AX, 1'b0);
        exp_push("split_lanes_ax", SRC_RD0, 16'h4433);
        tick();

        wr(0, DX, 1'b0, 16'hAAAA);
        wr(1, DX, 1'b0, 16'hBBBB);
        rd(0, DX, 1'b0);
        rd(1, DH, 1'b1);
        exp_push("prio_dx", SRC_RD0, 16'hBBBB);
        exp_push("prio_dh", SRC_RD1, 16'h00BB);
        tick();

        wr(0, SI, 1'b0, 16'hA5A5);
        exp_push("si_load", SRC_SI, 16'hA5A5);
        tick();
        save = 1'b1;
        wr(0, DI, 1'b0, 16'h0D0D);
        exp_push("save_si_kept", SRC_SI, 16'hA5A5);
        tick();
        wr(0, SI, 1'b0, 16'h0001);
        wr(1, DI, 1'b0, 16'h0000);
        exp_push("si_overwrite", SRC_SI, 16'h0001);
        exp_push("di_overwrite", SRC_DI, 16'h0000);
        tick();
        restore = 1'b1;
        wr(0, SI, 1'b0, 16'hBEEF);
        rd(0, SI, 1'b0);
        rd(1, DI, 1'b0);
        exp_push("restore_si", SRC_SI, 16'hA5A5);
        exp_push("restore_rd_bypass", SRC_RD0, 16'hA5A5);
        exp_push("restore_di_post_write_save", SRC_DI, 16'h0D0D);
        tick();

        wr(0, SI, 1'b0, 16'h0002);
        tick();
        save = 1'b1;
        tick();
        wr(0, SI, 1'b0, 16'h0001);
        exp_push("swap_setup_si", SRC_SI, 16'h0001);
        tick();
        save    = 1'b1;
        restore = 1'b1;
        wr(0, SI, 1'b0, 16'hFFFF);
        exp_push("swap1_si", SRC_SI, 16'h0002);
        tick();
        save    = 1'b1;
        restore = 1'b1;
        exp_push("swap2_si", SRC_SI, 16'h0001);
        tick();

        wr(0, BP, 1'b0, 16'h3C3C);
        rd(0, BP, 1'b0);
        rd(1, BP, 1'b0);
        exp_push("bp_load", SRC_BP, 16'h3C3C);
        exp_push("bp_rd0", SRC_RD0, 16'h3C3C);
        tick();
        #3;
        reset = 1'b1;
        #1;
        exp_push("async_bp", SRC_BP, 16'h0000);
        exp_push("async_rd0", SRC_RD0, 16'h0000);
        exp_push("async_rd1", SRC_RD1, 16'h0000);
        exp_push("async_si", SRC_SI, 16'h0000);
        compare_all();
        wr(0, BP, 1'b0, 16'h1234);
        @(negedge clk);
        reset = 1'b0;
        exp_push("post_reset_bp", SRC_BP, 16'h1234);
        exp_push("post_reset_rd1", SRC_RD1, 16'h1234);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
